// File: rtl/pwm_multi_if.sv
// Configuration/status bundle for pwm_multi: master drives settings, slave (the PWM core) returns status and outputs.
// NUM_CH and WIDTH must match the parameters of the pwm_multi instance it connects to.
interface pwm_multi_if #(
    parameter int unsigned NUM_CH = 4,
    parameter int unsigned WIDTH  = 16
);
    logic                    boot_mode;
    logic                    glb_enable;
    logic [NUM_CH-1:0]       ch_enable;
    logic [NUM_CH-1:0]       ch_invert;
    logic                    center_mode;
    logic [WIDTH-1:0]        pwm_div;
    logic [WIDTH-1:0]        pwm_period;
    logic [NUM_CH*WIDTH-1:0] pwm_duty;
    logic                    update_req;
    logic                    update_pending;
    logic                    period_tick;
    logic [NUM_CH-1:0]       pwm_out;

    modport master (
        output boot_mode, glb_enable, ch_enable, ch_invert, center_mode,
               pwm_div, pwm_period, pwm_duty, update_req,
        input  update_pending, period_tick, pwm_out
    );

    modport slave (
        input  boot_mode, glb_enable, ch_enable, ch_invert, center_mode,
               pwm_div, pwm_period, pwm_duty, update_req,
        output update_pending, period_tick, pwm_out
    );
endinterface

// File: rtl/pwm_multi.sv
// Multi-channel PWM: shared prescaler and period counter, shadowed div/period/duty loaded at period boundaries.
// Define PWM_CENTER_EN to build the center-aligned (up/down) counting mode selected by center_mode.
module pwm_multi #(
    parameter int unsigned NUM_CH       = 4,
    parameter int unsigned WIDTH        = 16,
    parameter int unsigned DEBUG_PERIOD = 9999,
    parameter int unsigned DEBUG_DUTY   = 1000
) (
    input  logic       clk,
    input  logic       reset,
    pwm_multi_if.slave bus
);
    localparam logic [WIDTH-1:0] DBG_PERIOD = WIDTH'(DEBUG_PERIOD);
    localparam logic [WIDTH-1:0] DBG_DUTY   = WIDTH'(DEBUG_DUTY);
    localparam logic [WIDTH-1:0] ONE        = WIDTH'(1);

    logic [WIDTH-1:0]        div_cnt_q, div_cnt_d;
    logic [WIDTH-1:0]        pwm_cnt_q, pwm_cnt_d;
    logic [WIDTH-1:0]        sh_div_q, sh_div_d;
    logic [WIDTH-1:0]        sh_period_q, sh_period_d;
    logic [NUM_CH*WIDTH-1:0] sh_duty_q, sh_duty_d;
    logic                    pending_q, pending_d;
    logic                    tick_q, tick_d;
    logic [NUM_CH-1:0]       out_q, out_d;

    logic                    run, div_tick, boundary, load;
    logic [WIDTH-1:0]        eff_div, eff_period;
    logic [NUM_CH*WIDTH-1:0] eff_duty;
    logic [NUM_CH-1:0]       eff_en, eff_inv;

`ifdef PWM_CENTER_EN
    typedef enum logic {DIR_UP, DIR_DOWN} dir_e;
    dir_e dir_q, dir_d;
    logic sh_center_q, sh_center_d;
`endif

    always_comb begin
        run        = bus.boot_mode | bus.glb_enable;
        eff_div    = (sh_div_q == '0) ? ONE : sh_div_q;
        eff_period = sh_period_q;
        eff_duty   = sh_duty_q;
        eff_en     = bus.ch_enable;
        eff_inv    = bus.ch_invert;
        if (bus.boot_mode) begin
            eff_div    = ONE;
            eff_period = DBG_PERIOD;
            eff_duty   = {NUM_CH{DBG_DUTY}};
            eff_en     = '1;
            eff_inv    = '0;
        end

        // >= so a div_cnt left over from a larger divider still ticks once boot_mode forces DIV=1
        div_tick  = run & (div_cnt_q >= eff_div - ONE);
        div_cnt_d = div_tick ? '0 : div_cnt_q + ONE;
        pwm_cnt_d = pwm_cnt_q;
        boundary  = 1'b0;
`ifdef PWM_CENTER_EN
        dir_d = dir_q;
        if (div_tick) begin
            if (!sh_center_q) begin
                dir_d = DIR_UP;
                if (pwm_cnt_q >= eff_period) begin
                    pwm_cnt_d = '0;
                    boundary  = 1'b1;
                end else begin
                    pwm_cnt_d = pwm_cnt_q + ONE;
                end
            end else if (dir_q == DIR_UP) begin
                // Peak is held for one div_tick; a period of 0 or 1 turns straight back into the valley
                if (pwm_cnt_q < eff_period) begin
                    pwm_cnt_d = pwm_cnt_q + ONE;
                end else if (eff_period > ONE) begin
                    pwm_cnt_d = pwm_cnt_q - ONE;
                    dir_d     = DIR_DOWN;
                end else begin
                    pwm_cnt_d = '0;
                    boundary  = 1'b1;
                end
            end else if (pwm_cnt_q > ONE) begin
                pwm_cnt_d = pwm_cnt_q - ONE;
            end else begin
                pwm_cnt_d = '0;
                boundary  = 1'b1;
                dir_d     = DIR_UP;
            end
        end
`else
        if (div_tick) begin
            if (pwm_cnt_q >= eff_period) begin
                pwm_cnt_d = '0;
                boundary  = 1'b1;
            end else begin
                pwm_cnt_d = pwm_cnt_q + ONE;
            end
        end
`endif

        load      = 1'b0;
        pending_d = pending_q;
        if (!run) begin
            div_cnt_d = '0;
            pwm_cnt_d = '0;
            load      = 1'b1;
            pending_d = 1'b0;
`ifdef PWM_CENTER_EN
            dir_d     = DIR_UP;
`endif
        end else if (boundary) begin
            load      = pending_q | bus.update_req;
            pending_d = 1'b0;
        end else if (bus.update_req) begin
            pending_d = 1'b1;
        end
        tick_d = boundary;

        sh_div_d    = load ? bus.pwm_div    : sh_div_q;
        sh_period_d = load ? bus.pwm_period : sh_period_q;
        sh_duty_d   = load ? bus.pwm_duty   : sh_duty_q;
`ifdef PWM_CENTER_EN
        sh_center_d = load ? bus.center_mode : sh_center_q;
`endif

        for (int unsigned i = 0; i < NUM_CH; i++) begin
            out_d[i] = (run & eff_en[i] & (pwm_cnt_q < eff_duty[i*WIDTH +: WIDTH])) ^ eff_inv[i];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            div_cnt_q   <= '0;
            pwm_cnt_q   <= '0;
            sh_div_q    <= '0;
            sh_period_q <= '0;
            sh_duty_q   <= '0;
            pending_q   <= 1'b0;
            tick_q      <= 1'b0;
            out_q       <= '0;
        end else begin
            div_cnt_q   <= div_cnt_d;
            pwm_cnt_q   <= pwm_cnt_d;
            sh_div_q    <= sh_div_d;
            sh_period_q <= sh_period_d;
            sh_duty_q   <= sh_duty_d;
            pending_q   <= pending_d;
            tick_q      <= tick_d;
            out_q       <= out_d;
        end
    end

`ifdef PWM_CENTER_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            dir_q       <= DIR_UP;
            sh_center_q <= 1'b0;
        end else begin
            dir_q       <= dir_d;
            sh_center_q <= sh_center_d;
        end
    end
`endif

    assign bus.update_pending = pending_q;
    assign bus.period_tick    = tick_q;
    assign bus.pwm_out        = out_q;
endmodule
